// File: rtl/store_pkg.sv
// store_pkg: funct3 codes, FSM states and constants shared by the store sequencer.
package store_pkg;
  localparam logic [2:0] SB = 3'h0;
  localparam logic [2:0] SH = 3'h1;
  localparam logic [2:0] SW = 3'h2;
  localparam logic [31:0] ZERO = 32'b0;
  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE, ERR} state_t;
endpackage

// File: rtl/store_merge.sv
// store_merge: drops the SB byte / SH half of rs2_value into its lane of mem_read_data; SW passes rs2_value.
module store_merge
  import store_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] rs2_value,
  input  logic [31:0] mem_read_data,
  output logic [31:0] merged
);
  always_comb begin
    merged = mem_read_data;
    if (funct3 == SW) merged = rs2_value;
    else if (funct3 == SH) merged[{offset[1], 4'b0} +: 16] = rs2_value[15:0];
    else merged[{offset, 3'b0} +: 8] = rs2_value[7:0];
  end
endmodule

// File: rtl/store_rmw_sequencer.sv
// store_rmw_sequencer: SB/SH/SW store sequencer with read-modify-write onto a single-port word memory.
// STORE_BYTE_ENABLE_EN: adds mem_byte_enable and writes sub-word stores directly with lane enables.
module store_rmw_sequencer
  import store_pkg::*;
#(
  parameter int READ_TIMEOUT  = 16,
  parameter int TIMEOUT_WIDTH = 5
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        store_valid,
  output logic        store_ready,
  input  logic [2:0]  funct3,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [31:0] immediate12_store,
  output logic [31:0] mem_addr,
  output logic        mem_read_req,
  input  logic        mem_read_valid,
  input  logic [31:0] mem_read_data,
  output logic        mem_write_req,
  input  logic        mem_write_ready,
  output logic [31:0] mem_write_data,
`ifdef STORE_BYTE_ENABLE_EN
  output logic [3:0]  mem_byte_enable,
`endif
  output logic        store_done,
  output logic        store_error
);
`ifdef STORE_BYTE_ENABLE_EN
  localparam bit DIRECT = 1'b1;
`else
  localparam bit DIRECT = 1'b0;
`endif
  state_t state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0] off_q, off_d;
  logic [2:0] f3_q, f3_d;
  logic [31:0] rs2_q, rs2_d, addr_q, addr_d, wdata_q, wdata_d;
  logic ready_q, ready_d, rreq_q, rreq_d, wreq_q, wreq_d, done_q, done_d, err_q, err_d;
  logic [31:0] eff, merged, m_rs2, m_rd;
  logic [2:0] m_f3;
  logic [1:0] m_off;
  logic idle, accept, bad;

  assign eff    = rs1_value + immediate12_store;
  assign idle   = state_q == IDLE;
  assign accept = store_valid & ready_q;
  assign bad    = (funct3 > SW) || (funct3 == SH && eff[0]) || (funct3 == SW && eff[1:0] != 2'b00);

  // At accept the merge sees the live request with rs2 replicated as "old" data (byte-enable path);
  // in WAIT it sees the captured request against the real read data.
  assign m_f3  = idle ? funct3 : f3_q;
  assign m_off = idle ? eff[1:0] : off_q;
  assign m_rs2 = idle ? rs2_value : rs2_q;
  assign m_rd  = idle ? (m_f3 == SH ? {2{m_rs2[15:0]}} : {4{m_rs2[7:0]}}) : mem_read_data;

  store_merge u_merge (
    .funct3       (m_f3),
    .offset       (m_off),
    .rs2_value    (m_rs2),
    .mem_read_data(m_rd),
    .merged       (merged)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    off_d   = off_q;
    f3_d    = f3_q;
    rs2_d   = rs2_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: if (accept) begin
        off_d   = eff[1:0];
        f3_d    = funct3;
        rs2_d   = rs2_value;
        addr_d  = {eff[31:2], 2'b00};
        wdata_d = merged;
        state_d = bad ? ERR : (funct3 == SW || DIRECT) ? WRITE : READ;
      end
      READ: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mem_read_valid) begin
          wdata_d = merged;
          state_d = WRITE;
        end else if (cnt_q == TIMEOUT_WIDTH'(READ_TIMEOUT - 1)) state_d = ERR;
      end
      WRITE: if (mem_write_ready) state_d = DONE;
      default: state_d = IDLE;
    endcase
    ready_d = state_d == IDLE;
    rreq_d  = state_d == READ;
    wreq_d  = state_d == WRITE;
    done_d  = state_d == DONE;
    err_d   = state_d == ERR;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      rs2_q   <= ZERO;
      addr_q  <= ZERO;
      wdata_q <= ZERO;
      ready_q <= 1'b1;
      rreq_q  <= 1'b0;
      wreq_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      rs2_q   <= rs2_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ready_q <= ready_d;
      rreq_q  <= rreq_d;
      wreq_q  <= wreq_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

`ifdef STORE_BYTE_ENABLE_EN
  logic [3:0] be_q, be_d;
  always_comb begin
    be_d = be_q;
    if (idle && accept) be_d = funct3 == SW ? 4'hF : funct3 == SH ? 4'b0011 << {eff[1], 1'b0} : 4'b0001 << eff[1:0];
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) be_q <= '0;
    else be_q <= be_d;
  end
  assign mem_byte_enable = be_q;
`endif

  assign store_ready    = ready_q;
  assign mem_addr       = addr_q;
  assign mem_read_req   = rreq_q;
  assign mem_write_req  = wreq_q;
  assign mem_write_data = wdata_q;
  assign store_done     = done_q;
  assign store_error    = err_q;
endmodule

// File: tb/tb_store_rmw_sequencer.sv
// tb_store_rmw_sequencer: directed plus randomized stores against a lane-arithmetic reference model.
module tb_store_rmw_sequencer;
  localparam int T = 16;
  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        store_valid = 1'b0;
  logic        store_ready;
  logic [2:0]  funct3 = '0;
  logic [31:0] rs1_value = '0, rs2_value = '0, immediate12_store = '0;
  logic [31:0] mem_addr, mem_read_data = '0, mem_write_data;
  logic        mem_read_req, mem_read_valid = 1'b0, mem_write_req, mem_write_ready = 1'b0;
  logic        store_done, store_error;
`ifdef STORE_BYTE_ENABLE_EN
  logic [3:0]  mem_byte_enable;
  localparam bit BE = 1'b1;
`else
  localparam bit BE = 1'b0;
`endif
  int n_checks = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  store_rmw_sequencer #(.READ_TIMEOUT(T), .TIMEOUT_WIDTH(5)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .store_valid      (store_valid),
    .store_ready      (store_ready),
    .funct3           (funct3),
    .rs1_value        (rs1_value),
    .rs2_value        (rs2_value),
    .immediate12_store(immediate12_store),
    .mem_addr         (mem_addr),
    .mem_read_req     (mem_read_req),
    .mem_read_valid   (mem_read_valid),
    .mem_read_data    (mem_read_data),
    .mem_write_req    (mem_write_req),
    .mem_write_ready  (mem_write_ready),
    .mem_write_data   (mem_write_data),
`ifdef STORE_BYTE_ENABLE_EN
    .mem_byte_enable  (mem_byte_enable),
`endif
    .store_done       (store_done),
    .store_error      (store_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] rs2, input logic [31:0] old);
    int sh;
    logic [31:0] mask;
    if (f3 == 3'd2) return rs2;
    if (BE) return (f3 == 3'd0) ? {4{rs2[7:0]}} : {2{rs2[15:0]}};
    sh = (f3 == 3'd0) ? 8 * int'(off) : 16 * (int'(off) / 2);
    mask = ((f3 == 3'd0) ? 32'hFF : 32'hFFFF) << sh;
    return (old & ~mask) | ((rs2 << sh) & mask);
  endfunction

  function automatic bit ref_bad(input logic [2:0] f3, input logic [1:0] off);
    return f3 > 3'd2 || (f3 == 3'd1 && off[0]) || (f3 == 3'd2 && off != 2'd0);
  endfunction

  // rlat: cycles after the first WAIT cycle before read data arrives (-1 = never); wlat: write-ready delay.
  task automatic run_store(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] imm, input logic [31:0] rs2,
                           input logic [31:0] rdata, input int rlat, input int wlat, output logic [31:0] wd_obs);
    int c, r, w, nr, nw, nd, ne, endc, exp_end;
    bit fin, unstable, bad, tmo, rmw;
    logic [31:0] eff, addr_obs;
    logic [3:0] be_obs, be_exp;
    eff = rs1 + imm;
    bad = ref_bad(f3, eff[1:0]);
    rmw = !bad && !BE && f3 != 3'd2;
    tmo = rmw && (rlat < 0 || rlat > T - 1);
    @(negedge clock);
    chk("ready_idle", store_ready, 1);
    funct3 = f3; rs1_value = rs1; immediate12_store = imm; rs2_value = rs2; store_valid = 1'b1;
    @(posedge clock);
    c = 0; r = 0; w = 0; nr = 0; nw = 0; nd = 0; ne = 0; endc = 0; fin = 0; unstable = 0;
    addr_obs = '0; wd_obs = '0; be_obs = '0;
    while (!fin && c < 64) begin
      c++;
      @(negedge clock);
      if (c == 1) begin
        store_valid = 1'b0;
        funct3 = 3'($urandom); rs1_value = $urandom; rs2_value = $urandom; immediate12_store = $urandom;
        chk("ready_busy", store_ready, 0);
      end
      if (mem_read_req) begin
        nr++;
        if (r == 0) begin r = c; addr_obs = mem_addr; end
      end
      if (mem_write_req) begin
        nw++;
        if (w == 0) begin
          w = c;
          wd_obs = mem_write_data;
          if (r == 0) addr_obs = mem_addr;
`ifdef STORE_BYTE_ENABLE_EN
          be_obs = mem_byte_enable;
`endif
        end
        if (mem_write_data !== wd_obs || mem_addr !== addr_obs) unstable = 1;
      end
      if (store_done) nd++;
      if (store_error) ne++;
      if (store_done || store_error) begin fin = 1; endc = c; end
      mem_read_valid  = (r > 0 && rlat >= 0 && c == r + 1 + rlat) || mem_write_req;
      mem_read_data   = (r > 0 && rlat >= 0 && c == r + 1 + rlat) ? rdata : ~rdata;
      mem_write_ready = (w > 0 && c >= w + wlat) || mem_read_req;
    end
    mem_read_valid = 1'b0;
    mem_write_ready = 1'b0;
    chk("finished", fin, 1);
    exp_end = bad ? 1 : tmo ? T + 2 : rmw ? 4 + rlat + wlat : 2 + wlat;
    chk("read_reqs", nr, rmw ? 1 : 0);
    chk("write_cycles", nw, (bad || tmo) ? 0 : wlat + 1);
    chk("done_pulses", nd, (bad || tmo) ? 0 : 1);
    chk("error_pulses", ne, (bad || tmo) ? 1 : 0);
    chk("end_cycle", endc, exp_end);
    chk("write_stable", unstable, 0);
    if (!bad) chk("mem_addr", addr_obs, {eff[31:2], 2'b00});
    if (!bad && !tmo) chk("write_data", wd_obs, ref_word(f3, eff[1:0], rs2, rdata));
    be_exp = (f3 == 3'd2) ? 4'hF : (f3 == 3'd1) ? 4'(3 << (eff[1:0] & 2'b10)) : 4'(1 << eff[1:0]);
    if (BE && !bad) chk("byte_enable", be_obs, be_exp);
    @(negedge clock);
    chk("ready_after", store_ready, 1);
  endtask

  initial begin
    logic [31:0] wd, rs1, imm;
    logic [2:0] f3;
    int pick, rl, nd;
    #1 reset_n = 1'b0;
    #1;
    chk("rst_ready", store_ready, 1);
    chk("rst_rreq", mem_read_req, 0);
    chk("rst_wreq", mem_write_req, 0);
    chk("rst_done", store_done, 0);
    chk("rst_err", store_error, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_write_data, 0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;

    run_store(3'd0, 32'h1000, 32'd3, 32'hAB, 32'h11223344, 0, 0, wd);
    if (!BE) chk("plan_sb", wd, 32'hAB223344);
    run_store(3'd1, 32'h2000, 32'd2, 32'hBEEF, 32'hCAFED00D, 0, 0, wd);
    if (!BE) chk("plan_sh", wd, 32'hBEEFD00D);
    run_store(3'd1, 32'h2000, 32'd1, 32'hBEEF, 32'hCAFED00D, 0, 0, wd);
    run_store(3'd2, 32'h10, 32'hFFFFFFF4, 32'hDEADBEEF, 32'h0, 0, 3, wd);
    chk("plan_sw", wd, 32'hDEADBEEF);
    run_store(3'd0, 32'h300, 32'd1, 32'h77, 32'h01020304, -1, 0, wd);
    run_store(3'd0, 32'h300, 32'd1, 32'h77, 32'h01020304, T - 1, 1, wd);
    run_store(3'd5, 32'h400, 32'd0, 32'h1234, 32'h0, 0, 0, wd);
    run_store(3'd0, 32'h500, 32'd2, 32'h5A, 32'h89ABCDEF, 2, 0, wd);
    if (BE) chk("plan_be_sb", wd, 32'h5A5A5A5A);

    // Reset while waiting for read data: strobes drop at once and nothing completes.
    @(negedge clock);
    funct3 = 3'd0; rs1_value = 32'h600; immediate12_store = 32'd0; rs2_value = 32'h11; store_valid = 1'b1;
    @(posedge clock);
    #1 store_valid = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_ready", store_ready, 1);
    chk("midrst_rreq", mem_read_req, 0);
    chk("midrst_wreq", mem_write_req, 0);
    chk("midrst_done", store_done, 0);
    chk("midrst_err", store_error, 0);
    @(negedge clock) reset_n = 1'b1;
    nd = 0;
    repeat (4) begin
      @(negedge clock);
      if (store_done || store_error || mem_write_req || mem_read_req) nd++;
    end
    chk("midrst_quiet", nd, 0);
    chk("midrst_ready_after", store_ready, 1);

    for (int i = 0; i < 40; i++) begin
      f3 = ($urandom % 8 < 6) ? 3'($urandom % 3) : 3'(3 + $urandom % 5);
      rs1 = $urandom;
      imm = {{20{1'b0}}, 12'($urandom)};
      imm = {{20{imm[11]}}, imm[11:0]};
      if ($urandom % 2 == 1) rs1[1:0] = 2'b00 - imm[1:0];
      pick = $urandom % 8;
      rl = pick < 4 ? pick : pick == 4 ? -1 : pick == 5 ? T - 1 : pick == 6 ? T : 0;
      run_store(f3, rs1, imm, $urandom, $urandom, rl, int'($urandom % 4), wd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/store_rmw_sequencer.md
Name: store_rmw_sequencer

Overview:
Sequences RISC-V SB/SH/SW stores onto a single-port 32-bit data memory. Sub-word stores are done as read-modify-write; the byte/half is merged into the lane selected by the byte offset. Sits between decode/execute (request side) and the data-memory port. It replaces ad-hoc combinational store merging with a handshaked FSM.

Parameters:
READ_TIMEOUT, 16, cycles to wait for mem_read_valid before flagging an error (minimum 2)
TIMEOUT_WIDTH, 5, width of the timeout counter; must hold READ_TIMEOUT

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
store_valid  input  1  store request present
store_ready  output  1  sequencer can accept a request (high only in IDLE)
funct3  input  3  0=SB, 1=SH, 2=SW, others illegal
rs1_value  input  32  base address
rs2_value  input  32  store data
immediate12_store  input  32  sign-extended offset
mem_addr  output  32  word address, bits [1:0] always 0
mem_read_req  output  1  one-cycle read strobe
mem_read_valid  input  1  read data valid
mem_read_data  input  32  read data
mem_write_req  output  1  write strobe, held until mem_write_ready
mem_write_ready  input  1  memory accepted the write
mem_write_data  output  32  merged word
store_done  output  1  one-cycle pulse on write accept
store_error  output  1  one-cycle pulse: misaligned, illegal funct3 or read timeout

Behaviour:
- Reset: all outputs 0, except store_ready=1 (IDLE). State is IDLE; the captured registers and timeout counter are cleared.
- Accept on store_valid & store_ready. Capture eff = rs1_value + immediate12_store (mod 2^32), funct3, rs2_value.
- Checks at accept: SH with eff[0]=1, SW with eff[1:0]!=0, or funct3>2 -> state ERR; no memory access occurs.
- States:
  - IDLE -> READ (SB/SH) or WRITE (SW).
  - READ: mem_read_req=1 for exactly one cycle; mem_addr={eff[31:2],2'b00}; go to WAIT.
  - WAIT: counter increments each cycle. On mem_read_valid, latch the merged word and go to WRITE. If the counter reaches READ_TIMEOUT first, go to ERR. If mem_read_valid arrives in the same cycle the counter reaches READ_TIMEOUT, the data wins.
  - WRITE: mem_write_req=1, mem_addr and mem_write_data stable. On mem_write_ready go to DONE.
  - DONE: store_done=1 for one cycle -> IDLE.
  - ERR: store_error=1 for one cycle -> IDLE.
- Merge rules:
  - SB: byte lane eff[1:0] = rs2_value[7:0]; other lanes from mem_read_data.
  - SH: half lane eff[1] = rs2_value[15:0]; other half from mem_read_data.
  - SW: rs2_value.
- Latency with zero-wait memory:
  - SW: accept -> write strobe next cycle -> done 1 cycle after ready.
  - SB/SH: accept, READ, WAIT (>=1), WRITE, DONE. Minimum 4 cycles from accept to done.
- mem_read_valid outside WAIT is ignored. mem_write_ready outside WRITE is ignored.
- store_valid while busy is not accepted. The requester holds inputs until store_ready & store_valid.
- reset_n low mid-operation: immediate return to IDLE. Strobes deassert asynchronously. No done or error pulse is produced.

Optional Feature:
STORE_BYTE_ENABLE_EN
- Defined: adds output mem_byte_enable[3:0]. SB/SH skip READ/WAIT and go straight to WRITE with lane enables (SB 0001<<eff[1:0], SH 0011<<{eff[1],1'b0}, SW 1111). mem_write_data carries rs2 data replicated into every lane. mem_read_req is never asserted.
- Undefined: read-modify-write path as above; port absent.

Decomposition:
- Shared package store_pkg:
  - funct3 constants SB=3'h0, SH=3'h1, SW=3'h2
  - FSM state enum IDLE, READ, WAIT, WRITE, DONE, ERR (3-bit)
  - ZERO 32'b0
- One sub-module, store_merge: combinational lane merge. Inputs funct3, offset[1:0], rs2_value, mem_read_data. Output merged word. It is reused by the byte-enable replication path.

Test Plan:
- SB: rs1=0x1000, imm=3, rs2=0xAB, read data 0x11223344 -> mem_addr 0x1000, write data 0xAB223344, store_done pulses once.
- SH: rs1=0x2000, imm=2, rs2=0xBEEF, read 0xCAFED00D -> write 0xBEEFD00D. SH at offset 1 -> store_error, no read_req/write_req.
- SW: rs1=0x10, imm=0xFFFFFFF4 (-12), rs2=0xDEADBEEF -> mem_addr 0x4, no read_req, write 0xDEADBEEF. mem_write_ready delayed 3 cycles -> mem_write_req held steady for 3 cycles.
- Timeout: SB with mem_read_valid never asserted -> store_error exactly READ_TIMEOUT cycles after WAIT entry, then store_ready=1. Repeat with valid arriving on the timeout cycle -> write proceeds, no error.
- funct3=3'h5 -> store_error, no memory traffic. reset_n pulsed low during WAIT -> outputs 0 at once, store_ready=1 after release, no done pulse.
- STORE_BYTE_ENABLE_EN defined: SB at offset 2, rs2=0x5A -> mem_byte_enable=0100, write data 0x5A5A5A5A, no read_req, done 2 cycles after accept with zero-wait memory.
